aes_bram_port: RTL and testbench

//  Memory-side stage directly downstream of the AES control FSM.
//  - Converts the single-word request handshake into native single-port BRAM cycles:
//    aes_start_read / aes_start_write in, bram_complete back.
//  - Handles the configurable BRAM read latency and byte-to-word address translation.
//  - Returns read data and flags illegal addresses.

---
 rtl/aes_bram_port.sv | 177 +++++++++++++++++
 tb/tb_aes_bram_port.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_bram_port.sv
// Request-to-BRAM bridge for the AES control FSM: word-address translation, read latency
// handling and sticky address checking. Optional counters under AES_BRAM_PORT_STATS_EN.
module aes_bram_port #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              aes_clk,
  input  logic              aes_rst_n,
  input  logic              aes_start_read,
  input  logic              aes_start_write,
  input  logic [31:0]       aes_bram_addr,
  input  logic [31:0]       aes_bram_write_data,
  output logic [31:0]       aes_bram_read_data,
  output logic              bram_complete,
  output logic              addr_err,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  input  logic [31:0]       bram_dout
`ifdef AES_BRAM_PORT_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  typedef enum logic [2:0] {
    StIdle, StRdIssue, StRdWait, StWrIssue, StDone, StRecover
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              is_rd_q, is_rd_d;
  logic              rd_pend_q, rd_pend_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              complete_q, complete_d;
  logic              err_q, err_d;
  logic              en_q, en_d;
  logic [3:0]        we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              bad_addr;
`ifdef AES_BRAM_PORT_STATS_EN
  logic [31:0]       rd_cnt_q, rd_cnt_d;
  logic [31:0]       wr_cnt_q, wr_cnt_d;
`endif

  // Misaligned byte address or bits above the word-address range.
  assign bad_addr = (aes_bram_addr[1:0] != 2'b00) ||
                    ((aes_bram_addr >> (ADDR_W + 2)) != 32'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_rd_d    = is_rd_q;
    rd_pend_d  = rd_pend_q;
    rdata_d    = rdata_q;
    complete_d = 1'b0;
    err_d      = err_q;
    en_d       = 1'b0;
    we_d       = 4'h0;
    addr_d     = addr_q;
    din_d      = 32'd0;
`ifdef AES_BRAM_PORT_STATS_EN
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (rd_pend_q) begin
          // Deferred half of a simultaneous read+write; address already latched.
          state_d   = StRdIssue;
          rd_pend_d = 1'b0;
          is_rd_d   = 1'b1;
          en_d      = 1'b1;
        end else if (aes_start_write) begin
          state_d   = StWrIssue;
          is_rd_d   = 1'b0;
          rd_pend_d = aes_start_read;
          en_d      = 1'b1;
          we_d      = 4'hF;
          din_d     = aes_bram_write_data;
          addr_d    = aes_bram_addr[ADDR_W+1:2];
          err_d     = err_q | bad_addr;
        end else if (aes_start_read) begin
          state_d   = StRdIssue;
          is_rd_d   = 1'b1;
          en_d      = 1'b1;
          addr_d    = aes_bram_addr[ADDR_W+1:2];
          err_d     = err_q | bad_addr;
        end
      end
      StRdIssue: begin
        if (READ_LATENCY <= 1) begin
          state_d = StDone;
        end else begin
          state_d = StRdWait;
          cnt_d   = 2'(READ_LATENCY - 2);
        end
      end
      StRdWait: begin
        if (cnt_q == 2'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StWrIssue: state_d = StDone;
      StDone: begin
        state_d    = StRecover;
        complete_d = 1'b1;
        if (is_rd_q) begin
          rdata_d = bram_dout;
        end
`ifdef AES_BRAM_PORT_STATS_EN
        if (is_rd_q) begin
          rd_cnt_d = rd_cnt_q + 32'd1;
        end else begin
          wr_cnt_d = wr_cnt_q + 32'd1;
        end
`endif
      end
      StRecover: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge aes_clk or negedge aes_rst_n) begin
    if (!aes_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 2'd0;
      is_rd_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      rdata_q    <= 32'd0;
      complete_q <= 1'b0;
      err_q      <= 1'b0;
      en_q       <= 1'b0;
      we_q       <= 4'h0;
      addr_q     <= '0;
      din_q      <= 32'd0;
`ifdef AES_BRAM_PORT_STATS_EN
      rd_cnt_q   <= 32'd0;
      wr_cnt_q   <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_rd_q    <= is_rd_d;
      rd_pend_q  <= rd_pend_d;
      rdata_q    <= rdata_d;
      complete_q <= complete_d;
      err_q      <= err_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
`ifdef AES_BRAM_PORT_STATS_EN
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
`endif
    end
  end

  assign aes_bram_read_data = rdata_q;
  assign bram_complete      = complete_q;
  assign addr_err           = err_q;
  assign bram_en            = en_q;
  assign bram_we            = we_q;
  assign bram_addr          = addr_q;
  assign bram_din           = din_q;
`ifdef AES_BRAM_PORT_STATS_EN
  assign rd_count           = rd_cnt_q;
  assign wr_count           = wr_cnt_q;
`endif

endmodule

// File: tb/tb_aes_bram_port.sv
// Bench for aes_bram_port: two instances (read latency 1 and 3) against a BRAM model and a
// word-level reference memory. Counter checks enabled with AES_BRAM_PORT_STATS_EN.
module tb_aes_bram_port;
  localparam int AW = 10;

  logic          aes_clk = 1'b0;
  logic          aes_rst_n = 1'b1;
  logic          start_rd [2];
  logic          start_wr [2];
  logic [31:0]   addr_in  [2];
  logic [31:0]   wdata_in [2];
  logic [31:0]   rdata    [2];
  logic          cpl      [2];
  logic          aerr     [2];
  logic          en       [2];
  logic [3:0]    we       [2];
  logic [AW-1:0] baddr    [2];
  logic [31:0]   din      [2];
  logic [31:0]   dout     [2];
  logic [31:0]   rdc      [2];
  logic [31:0]   wrc      [2];

  logic [31:0]   mem  [2][1024];
  logic [31:0]   pipe [2][4];

  logic [31:0]   ref_mem  [2][1024];
  bit            written  [2][1024];
  bit            err_ref  [2];
  int            rd_exp   [2];
  int            wr_exp   [2];
  int            tests = 0;
  int            fails = 0;

  always #5 aes_clk = ~aes_clk;

  aes_bram_port #(.ADDR_W(AW), .READ_LATENCY(1)) dut (
    .aes_clk(aes_clk), .aes_rst_n(aes_rst_n),
    .aes_start_read(start_rd[0]), .aes_start_write(start_wr[0]),
    .aes_bram_addr(addr_in[0]), .aes_bram_write_data(wdata_in[0]),
    .aes_bram_read_data(rdata[0]), .bram_complete(cpl[0]), .addr_err(aerr[0]),
    .bram_en(en[0]), .bram_we(we[0]), .bram_addr(baddr[0]), .bram_din(din[0]),
    .bram_dout(dout[0])
`ifdef AES_BRAM_PORT_STATS_EN
    , .rd_count(rdc[0]), .wr_count(wrc[0])
`endif
  );

  aes_bram_port #(.ADDR_W(AW), .READ_LATENCY(3)) dut3 (
    .aes_clk(aes_clk), .aes_rst_n(aes_rst_n),
    .aes_start_read(start_rd[1]), .aes_start_write(start_wr[1]),
    .aes_bram_addr(addr_in[1]), .aes_bram_write_data(wdata_in[1]),
    .aes_bram_read_data(rdata[1]), .bram_complete(cpl[1]), .addr_err(aerr[1]),
    .bram_en(en[1]), .bram_we(we[1]), .bram_addr(baddr[1]), .bram_din(din[1]),
    .bram_dout(dout[1])
`ifdef AES_BRAM_PORT_STATS_EN
    , .rd_count(rdc[1]), .wr_count(wrc[1])
`endif
  );

  // Single-port BRAM model with a fixed read pipeline per instance.
  always @(posedge aes_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (en[i] && we[i] == 4'hF) mem[i][baddr[i]] <= din[i];
      pipe[i][0] <= mem[i][baddr[i]];
      for (int k = 3; k > 0; k--) pipe[i][k] <= pipe[i][k-1];
    end
  end
  assign dout[0] = pipe[0][0];
  assign dout[1] = pipe[1][2];

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % 1024);
  endfunction

  function automatic bit bad_of(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'h1000);
  endfunction

  task automatic check_outputs_zero(input int i, input string nm);
    tests++;
    if (rdata[i] !== 32'd0 || cpl[i] !== 1'b0 || aerr[i] !== 1'b0 || en[i] !== 1'b0 ||
        we[i] !== 4'h0 || baddr[i] !== '0 || din[i] !== 32'd0) begin
      fails++;
      $display("FAIL %s[%0d]: got rd=%h cpl=%b err=%b en=%b we=%h a=%h din=%h required all 0",
               nm, i, rdata[i], cpl[i], aerr[i], en[i], we[i], baddr[i], din[i]);
    end
`ifdef AES_BRAM_PORT_STATS_EN
    tests++;
    if (rdc[i] !== 32'd0 || wrc[i] !== 32'd0) begin
      fails++;
      $display("FAIL %s_cnt[%0d]: got rd=%0d wr=%0d required 0", nm, i, rdc[i], wrc[i]);
    end
`endif
  endtask

  // One single-kind access with latency, enable, address and data checks.
  task automatic access(input int i, input bit is_wr, input logic [31:0] a,
                        input logic [31:0] d, input string nm);
    int n, en_n, w, exp_lat;
    bit done;
    logic [3:0] we_seen;
    logic [AW-1:0] addr_seen;
    @(negedge aes_clk);
    addr_in[i] = a; wdata_in[i] = d;
    start_wr[i] = is_wr; start_rd[i] = !is_wr;
    @(posedge aes_clk);
    #1 start_wr[i] = 1'b0; start_rd[i] = 1'b0;
    n = 0; en_n = 0; done = 0; we_seen = 4'h0; addr_seen = '0;
    forever begin
      @(negedge aes_clk);
      if (en[i]) begin en_n++; we_seen = we[i]; addr_seen = baddr[i]; end
      if (cpl[i]) begin done = 1; break; end
      if (n >= 20) break;
      @(posedge aes_clk);
      n++;
    end
    w = word_of(a);
    exp_lat = is_wr ? 2 : 1 + lat(i);
    err_ref[i] = err_ref[i] | bad_of(a);
    if (is_wr) begin ref_mem[i][w] = d; written[i][w] = 1; wr_exp[i]++; end
    else rd_exp[i]++;
    tests++;
    if (!done || n != exp_lat) begin
      fails++;
      $display("FAIL %s_latency[%0d]: got done=%0b n=%0d required %0d", nm, i, done, n, exp_lat);
    end
    tests++;
    if (en_n != 1 || we_seen !== (is_wr ? 4'hF : 4'h0) || int'(addr_seen) != w) begin
      fails++;
      $display("FAIL %s_issue[%0d]: got en_cycles=%0d we=%h addr=%0d required 1 %h %0d",
               nm, i, en_n, we_seen, addr_seen, is_wr ? 4'hF : 4'h0, w);
    end
    tests++;
    if (aerr[i] !== err_ref[i]) begin
      fails++;
      $display("FAIL %s_addr_err[%0d]: got %b required %b", nm, i, aerr[i], err_ref[i]);
    end
    if (!is_wr && written[i][w]) begin
      tests++;
      if (rdata[i] !== ref_mem[i][w]) begin
        fails++;
        $display("FAIL %s_rdata[%0d]: got %h required %h", nm, i, rdata[i], ref_mem[i][w]);
      end
    end
`ifdef AES_BRAM_PORT_STATS_EN
    tests++;
    if (rdc[i] !== 32'(rd_exp[i]) || wrc[i] !== 32'(wr_exp[i])) begin
      fails++;
      $display("FAIL %s_counts[%0d]: got rd=%0d wr=%0d required %0d %0d",
               nm, i, rdc[i], wrc[i], rd_exp[i], wr_exp[i]);
    end
`endif
    @(negedge aes_clk);
    tests++;
    if (cpl[i] !== 1'b0) begin
      fails++;
      $display("FAIL %s_pulse_width[%0d]: got %b required 0", nm, i, cpl[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge aes_clk);
    aes_rst_n = 1'b0;
    #2;
    @(negedge aes_clk);
    aes_rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin err_ref[i] = 0; rd_exp[i] = 0; wr_exp[i] = 0; end
  endtask

  task automatic test_reset();
    #1 aes_rst_n = 1'b0;
    #3;
    for (int i = 0; i < 2; i++) check_outputs_zero(i, "reset");
    @(negedge aes_clk);
    aes_rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] d;
    access(0, 1, 32'h10, 32'hDEADBEEF, "wr_0x10");
    access(0, 0, 32'h10, 32'h0, "rd_0x10");
    d = $urandom;
    access(1, 1, 32'h0, d, "wr_lat3");
    access(1, 0, 32'h0, 32'h0, "rd_lat3");
  endtask

  task automatic test_both();
    for (int i = 0; i < 2; i++) begin
      int pulses, en_n;
      logic [3:0] we_first, we_second;
      logic [31:0] d;
      d = $urandom;
      @(negedge aes_clk);
      addr_in[i] = 32'h20; wdata_in[i] = d; start_wr[i] = 1'b1; start_rd[i] = 1'b1;
      @(posedge aes_clk);
      #1 start_wr[i] = 1'b0; start_rd[i] = 1'b0;
      pulses = 0; en_n = 0; we_first = 4'h0; we_second = 4'hA;
      for (int c = 0; c < 30; c++) begin
        @(negedge aes_clk);
        if (en[i]) begin
          if (en_n == 0) we_first = we[i]; else we_second = we[i];
          en_n++;
        end
        if (cpl[i]) pulses++;
      end
      ref_mem[i][8] = d; written[i][8] = 1;
      wr_exp[i]++; rd_exp[i]++;
      tests++;
      if (pulses != 2 || en_n != 2) begin
        fails++;
        $display("FAIL both_pulses[%0d]: got pulses=%0d en=%0d required 2 2", i, pulses, en_n);
      end
      tests++;
      if (we_first !== 4'hF || we_second !== 4'h0) begin
        fails++;
        $display("FAIL both_order[%0d]: got we=%h,%h required f,0", i, we_first, we_second);
      end
      tests++;
      if (rdata[i] !== d) begin
        fails++;
        $display("FAIL both_rdata[%0d]: got %h required %h", i, rdata[i], d);
      end
    end
  endtask

  task automatic test_addr_err();
    logic [31:0] d;
    d = $urandom;
    access(0, 1, 32'h13, d, "misaligned");
    access(0, 0, 32'h10, 32'h0, "sticky_rd");
    d = $urandom;
    access(0, 1, 32'h1000, d, "out_of_range");
    access(0, 0, 32'h0, 32'h0, "wrap_rd");
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int i, w;
      bit is_wr;
      i = int'($urandom_range(1, 0));
      w = int'($urandom_range(15, 0));
      is_wr = !written[i][w] || ($urandom_range(1, 0) == 1);
      access(i, is_wr, 32'(w * 4), $urandom, "random");
    end
  endtask

  task automatic test_reset_midread();
    int seen;
    @(negedge aes_clk);
    addr_in[1] = 32'h0; start_rd[1] = 1'b1;
    @(posedge aes_clk);
    #1 start_rd[1] = 1'b0;
    @(posedge aes_clk);
    #1 aes_rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) check_outputs_zero(i, "midread_reset");
    @(negedge aes_clk);
    aes_rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin err_ref[i] = 0; rd_exp[i] = 0; wr_exp[i] = 0; end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge aes_clk);
      if (cpl[1] || en[1]) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL aborted_access: got %0d active cycles required 0", seen);
    end
    access(1, 0, 32'h0, 32'h0, "post_reset_rd");
  endtask

  task automatic test_stats();
`ifdef AES_BRAM_PORT_STATS_EN
    do_reset();
    for (int k = 0; k < 4; k++) access(0, 1, 32'(k * 4), $urandom, "stats_wr");
    for (int k = 0; k < 4; k++) access(0, 0, 32'(k * 4), 32'h0, "stats_rd");
    tests++;
    if (rdc[0] !== 32'd4 || wrc[0] !== 32'd4) begin
      fails++;
      $display("FAIL stats_block: got rd=%0d wr=%0d required 4 4", rdc[0], wrc[0]);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_rd[i] = 1'b0; start_wr[i] = 1'b0; addr_in[i] = 32'd0; wdata_in[i] = 32'd0;
      err_ref[i] = 0; rd_exp[i] = 0; wr_exp[i] = 0;
      for (int w = 0; w < 1024; w++) begin ref_mem[i][w] = 32'd0; written[i][w] = 0; end
    end
    test_reset();
    test_write_read();
    test_both();
    test_addr_err();
    test_random();
    test_reset_midread();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
